// File: rtl/sprite_scan_renderer_if.sv
// Renderer-side signal bundle: scan strobes, bitmap ROM port and pixel outputs.
interface sprite_scan_renderer_if;
    logic       vstart;
    logic       load;
    logic       hstart;
    logic [3:0] rom_addr;
    logic [7:0] rom_bits;
    logic       gfx;
    logic       inloop;

    // Timing generator / ROM side.
    modport master (
        output vstart, load, hstart, rom_bits,
        input  rom_addr, gfx, inloop
    );

    // Renderer side.
    modport slave (
        input  vstart, load, hstart, rom_bits,
        output rom_addr, gfx, inloop
    );
endinterface

// File: rtl/sprite_scan_renderer.sv
// Walks an 8x16 one-bit sprite per scanline and serialises each ROM row as gfx, with X/Y repeat.
// Latency: row address one clock after a load rise; first pixel one clock after hstart.
// No backpressure: strobes arriving outside their state are dropped and the row waits for the next one.
module sprite_scan_renderer #(
    parameter int SCALE_X = 1,
    parameter int SCALE_Y = 1
) (
    input logic                  clk,
    input logic                  reset,
    sprite_scan_renderer_if.slave bus
);

    localparam logic [1:0] XREP_LAST = 2'(SCALE_X - 1);
    localparam logic [1:0] YREP_LAST = 2'(SCALE_Y - 1);

    typedef enum logic [2:0] {
        WAIT_VSTART,
        WAIT_LOAD,
        FETCH,
        WAIT_HSTART,
        DRAW,
        END_LINE
    } state_t;

    state_t     state;
    logic       load_q;
    logic       load_rise;
    logic [3:0] ycount;
    logic [1:0] yrep;
    logic [2:0] xcount;
    logic [1:0] xrep;
    logic [7:0] shreg;
    logic [3:0] rom_addr_q;

    // A load already high when WAIT_LOAD is entered never produces a rise.
    assign load_rise = bus.load & ~load_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WAIT_VSTART;
            load_q     <= 1'b0;
            ycount     <= 4'd0;
            yrep       <= 2'd0;
            xcount     <= 3'd0;
            xrep       <= 2'd0;
            shreg      <= 8'd0;
            rom_addr_q <= 4'd0;
        end else begin
            load_q <= bus.load;
            case (state)
                WAIT_VSTART: begin
                    if (bus.vstart) begin
                        ycount <= 4'd0;
                        yrep   <= 2'd0;
                        state  <= WAIT_LOAD;
                    end
                end
                WAIT_LOAD: begin
                    if (load_rise) begin
                        rom_addr_q <= ycount;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    shreg <= bus.rom_bits;
                    state <= WAIT_HSTART;
                end
                WAIT_HSTART: begin
                    if (bus.hstart) begin
                        xcount <= 3'd0;
                        xrep   <= 2'd0;
                        state  <= DRAW;
                    end
                end
                DRAW: begin
                    if (xrep == XREP_LAST) begin
                        xrep   <= 2'd0;
                        shreg  <= {shreg[6:0], 1'b0};
                        xcount <= xcount + 3'd1;
                        if (xcount == 3'd7) begin
                            state <= END_LINE;
                        end
                    end else begin
                        xrep <= xrep + 2'd1;
                    end
                end
                END_LINE: begin
                    // Repeated lines go back through WAIT_LOAD and refetch the same row.
                    if (yrep == YREP_LAST) begin
                        yrep   <= 2'd0;
                        ycount <= ycount + 4'd1;
                        state  <= (ycount == 4'hF) ? WAIT_VSTART : WAIT_LOAD;
                    end else begin
                        yrep  <= yrep + 2'd1;
                        state <= WAIT_LOAD;
                    end
                end
                default: state <= WAIT_VSTART;
            endcase
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.gfx      = (state == DRAW) & shreg[7];
    assign bus.inloop   = (state != WAIT_VSTART);

endmodule
